// File: rtl/mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_unit
//  Purpose  : Parametrised single-port synchronous RAM tile. It has a
//             registered read with a one-cycle read_valid strobe and selectable
//             read-during-write behaviour. An optional post-reset clear sweep
//             zeroes every word while busy is high.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH     width of write_data / read_data
//    DEPTH          number of words (>= 2, any integer)
//    ADDR_WIDTH     width of addr0 (2**ADDR_WIDTH >= DEPTH)
//    RDW_MODE       same-address read+write: 0 = read-old, 1 = write-first
//    CLEAR_ON_RESET 1 = zero all words after reset, 0 = contents kept
//  Ports
//    clk        in   single clock, rising edge
//    rst        in   synchronous active-high reset
//    addr0      in   word address shared by read and write
//    write_data in   data to store
//    write_en   in   write request
//    read_en    in   read request
//    read_data  out  registered read result (holds when no read)
//    read_valid out  read_data updated this cycle
//    busy       out  clear sweep in progress, requests ignored
//    err        out  out-of-range access flag (only with MEM_UNIT_ERR_EN)
//  Optional feature macro: MEM_UNIT_ERR_EN
// ============================================================================
module mem_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy
`ifdef MEM_UNIT_ERR_EN
  ,
  output logic                  err
`endif
);

  // Index width into the word array; DEPTH need not be a power of two.
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH extended one bit past the address so the range compare is a
  // full-width unsigned compare with no truncation or wrap.
  localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [c_idx_w-1:0]  c_last      = c_idx_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_idx_w-1:0]    r_ptr;
  logic [c_idx_w-1:0]    w_ptr_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  logic                  w_in_range;
  logic [c_idx_w-1:0]    w_idx;
  logic                  w_ready;
  logic                  w_rd_req;
  logic                  w_mem_we;
  logic [c_idx_w-1:0]    w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_fwd;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_in_range = ({1'b0, addr0} < c_depth_ext);
  // Only meaningful when w_in_range is true; every use is gated by it.
  assign w_idx      = addr0[c_idx_w-1:0];
  assign w_ready    = (r_state == ST_READY);
  assign w_rd_req   = w_ready && read_en;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: CLEAR walks the pointer once over all words, then
  // parks in READY until the next reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_next = r_ptr + 1'b1;
        if (r_ptr == c_last) begin
          w_state_next = ST_READY;
          w_ptr_next   = '0;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = ST_READY;
        w_ptr_next   = '0;
      end
    endcase
  end

  assign busy = (r_state == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Single write port: the sweep owns it during CLEAR, user writes in READY.
  // Nothing is written on a reset edge. Out-of-range writes are dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_idx;
    w_mem_wdata = write_data;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
      end else if (write_en && w_in_range) begin
        w_mem_we    = 1'b1;
      end
    end
  end

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read path with read-during-write selection. The port is single-address,
  // so a read and write in the same cycle always hit the same word.
  // --------------------------------------------------------------------------
  assign w_rd_word = r_mem[w_idx];

  generate
    if (RDW_MODE == 1) begin : g_rdw_write_first
      assign w_rd_fwd = write_en ? write_data : w_rd_word;
    end else begin : g_rdw_read_old
      assign w_rd_fwd = w_rd_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_req;
      if (w_rd_req) begin
        // Out-of-range reads still complete, returning zero.
        r_read_data <= w_in_range ? w_rd_fwd : '0;
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;

`ifdef MEM_UNIT_ERR_EN
  // --------------------------------------------------------------------------
  // Error flag: set for the cycle after any READY-state access outside
  // the array. Back-to-back bad accesses keep it high.
  // --------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_ready && (read_en || write_en) && !w_in_range;
    end
  end

  assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_unit
//  Purpose  : Directed self-checking bench for mem_unit (DEPTH=16).
//             u_old   : RDW_MODE=0, CLEAR_ON_RESET=1
//             u_new   : RDW_MODE=1, CLEAR_ON_RESET=1
//             u_nclr  : RDW_MODE=0, CLEAR_ON_RESET=0
//             All instances share clock, reset and request inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_unit;

  localparam int c_dw    = 32;
  localparam int c_aw    = 32;
  localparam int c_depth = 16;

  logic            clk;
  logic            rst;
  logic [c_aw-1:0] addr0;
  logic [c_dw-1:0] write_data;
  logic            write_en;
  logic            read_en;

  logic [c_dw-1:0] rd_old, rd_new, rd_nclr;
  logic            rv_old, rv_new, rv_nclr;
  logic            busy_old, busy_new, busy_nclr;
`ifdef MEM_UNIT_ERR_EN
  logic            err_old, err_new, err_nclr;
`endif

  int checks   = 0;
  int failures = 0;

  logic [c_dw-1:0] exp_mem [c_depth];

  mem_unit #(
    .DATA_WIDTH(c_dw), .DEPTH(c_depth), .ADDR_WIDTH(c_aw),
    .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_old (
    .clk(clk), .rst(rst), .addr0(addr0), .write_data(write_data),
    .write_en(write_en), .read_en(read_en),
    .read_data(rd_old), .read_valid(rv_old), .busy(busy_old)
`ifdef MEM_UNIT_ERR_EN
    , .err(err_old)
`endif
  );

  mem_unit #(
    .DATA_WIDTH(c_dw), .DEPTH(c_depth), .ADDR_WIDTH(c_aw),
    .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_new (
    .clk(clk), .rst(rst), .addr0(addr0), .write_data(write_data),
    .write_en(write_en), .read_en(read_en),
    .read_data(rd_new), .read_valid(rv_new), .busy(busy_new)
`ifdef MEM_UNIT_ERR_EN
    , .err(err_new)
`endif
  );

  mem_unit #(
    .DATA_WIDTH(c_dw), .DEPTH(c_depth), .ADDR_WIDTH(c_aw),
    .RDW_MODE(0), .CLEAR_ON_RESET(0)
  ) u_nclr (
    .clk(clk), .rst(rst), .addr0(addr0), .write_data(write_data),
    .write_en(write_en), .read_en(read_en),
    .read_data(rd_nclr), .read_valid(rv_nclr), .busy(busy_nclr)
`ifdef MEM_UNIT_ERR_EN
    , .err(err_nclr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [c_dw-1:0] obs,
                       input logic [c_dw-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic req(input logic we, input logic re,
                     input logic [c_aw-1:0] a, input logic [c_dw-1:0] d);
    write_en   = we;
    read_en    = re;
    addr0      = a;
    write_data = d;
  endtask

  initial begin
    rst = 1'b1;
    req(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < c_depth; i++) exp_mem[i] = '0;

    // ---------------- reset and sweep ----------------
    tick();
    tick();
    check("rst_busy_old",  {31'd0, busy_old},  32'd1);
    check("rst_busy_new",  {31'd0, busy_new},  32'd1);
    check("rst_busy_nclr", {31'd0, busy_nclr}, 32'd0);
    check("rst_rd_old",    rd_old,             32'd0);
    check("rst_rv_old",    {31'd0, rv_old},    32'd0);
`ifdef MEM_UNIT_ERR_EN
    check("rst_err_old",   {31'd0, err_old},   32'd0);
`endif
    rst = 1'b0;
    // busy is high for the 16 cycles before edges 1..16 and falls at edge 16.
    for (int i = 1; i <= c_depth; i++) begin
      tick();
      check($sformatf("sweep_busy_old_%0d", i), {31'd0, busy_old},
            (i < c_depth) ? 32'd1 : 32'd0);
      check($sformatf("sweep_busy_new_%0d", i), {31'd0, busy_new},
            (i < c_depth) ? 32'd1 : 32'd0);
    end

    // Back-to-back readback of the cleared array.
    for (int a = 0; a < c_depth; a++) begin
      req(1'b0, 1'b1, a, '0);
      tick();
      check($sformatf("clr_rv_%0d", a), {31'd0, rv_old}, 32'd1);
      check($sformatf("clr_rd_old_%0d", a), rd_old, 32'd0);
      check($sformatf("clr_rd_new_%0d", a), rd_new, 32'd0);
    end
    req(1'b0, 1'b0, '0, '0);
    tick();
    check("idle_rv_old", {31'd0, rv_old}, 32'd0);

    // ---------------- write / read ----------------
    req(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    exp_mem[5] = 32'hDEADBEEF;
    tick();
    check("wr_no_rv", {31'd0, rv_old}, 32'd0);
    req(1'b0, 1'b1, 32'd5, '0);
    tick();
    check("rd5_data", rd_old, 32'hDEADBEEF);
    check("rd5_rv",   {31'd0, rv_old}, 32'd1);
    req(1'b0, 1'b0, '0, '0);
    tick();
    check("hold_rv",   {31'd0, rv_old}, 32'd0);
    check("hold_data", rd_old, 32'hDEADBEEF);
    tick();
    check("hold_data2", rd_new, 32'hDEADBEEF);

    // ---------------- read during write ----------------
    req(1'b1, 1'b0, 32'd3, 32'h11111111);
    tick();
    req(1'b1, 1'b1, 32'd3, 32'h22222222);
    exp_mem[3] = 32'h22222222;
    tick();
    check("rdw_old_mode0", rd_old, 32'h11111111);
    check("rdw_new_mode1", rd_new, 32'h22222222);
    check("rdw_rv",        {31'd0, rv_old}, 32'd1);
    req(1'b0, 1'b1, 32'd3, '0);
    tick();
    check("rdw_follow_old", rd_old, 32'h22222222);
    check("rdw_follow_new", rd_new, 32'h22222222);

    // ---------------- out of range ----------------
    req(1'b1, 1'b0, 32'd16, 32'hCAFEF00D);
    tick();
`ifdef MEM_UNIT_ERR_EN
    check("oor_err_w16", {31'd0, err_old}, 32'd1);
`endif
    req(1'b1, 1'b0, 32'h80000000, 32'hCAFEF00D);
    tick();
`ifdef MEM_UNIT_ERR_EN
    check("oor_err_w8000", {31'd0, err_old}, 32'd1);
`endif
    for (int a = 0; a < c_depth; a++) begin
      req(1'b0, 1'b1, a, '0);
      tick();
      check($sformatf("oor_readback_old_%0d", a), rd_old, exp_mem[a]);
      check($sformatf("oor_readback_new_%0d", a), rd_new, exp_mem[a]);
    end
`ifdef MEM_UNIT_ERR_EN
    check("oor_err_clear", {31'd0, err_old}, 32'd0);
`endif
    req(1'b0, 1'b1, 32'd5, '0);
    tick();
    check("pre_oor_rd", rd_old, 32'hDEADBEEF);
    req(1'b0, 1'b1, 32'd16, '0);
    tick();
    check("oor_rd_data", rd_old, 32'd0);
    check("oor_rd_rv",   {31'd0, rv_old}, 32'd1);
`ifdef MEM_UNIT_ERR_EN
    check("oor_err_r16", {31'd0, err_old}, 32'd1);
`endif
    req(1'b0, 1'b0, '0, '0);
    tick();
`ifdef MEM_UNIT_ERR_EN
    check("oor_err_drop", {31'd0, err_old}, 32'd0);
`endif

    // ---------------- reset mid-sweep ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Out-of-range requests during the sweep: no valid, no err.
    req(1'b1, 1'b1, 32'd16, 32'hFFFFFFFF);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("mid_busy_%0d", i), {31'd0, busy_old}, 32'd1);
      check($sformatf("mid_rv_%0d", i),   {31'd0, rv_old},   32'd0);
`ifdef MEM_UNIT_ERR_EN
      check($sformatf("mid_err_%0d", i),  {31'd0, err_old},  32'd0);
`endif
    end
    rst = 1'b1;
    tick();
    check("mid_rst_busy", {31'd0, busy_old}, 32'd1);
    rst = 1'b0;
    // In-range writes during the restarted sweep must all be ignored.
    req(1'b1, 1'b1, 32'd5, 32'h12345678);
    for (int i = 1; i <= c_depth; i++) begin
      tick();
      check($sformatf("restart_busy_%0d", i), {31'd0, busy_old},
            (i < c_depth) ? 32'd1 : 32'd0);
      check($sformatf("restart_rv_%0d", i), {31'd0, rv_new}, 32'd0);
    end
    req(1'b0, 1'b1, 32'd5, '0);
    tick();
    check("restart_rd5_old", rd_old, 32'd0);
    check("restart_rd5_new", rd_new, 32'd0);
    req(1'b0, 1'b1, 32'd3, '0);
    tick();
    check("restart_rd3_old", rd_old, 32'd0);

    // ---------------- no-clear reset ----------------
    req(1'b1, 1'b0, 32'd9, 32'h0000ABCD);
    tick();
    req(1'b0, 1'b1, 32'd9, '0);
    tick();
    check("nclr_pre_rd", rd_nclr, 32'h0000ABCD);
    req(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    check("nclr_rst_busy", {31'd0, busy_nclr}, 32'd0);
    check("nclr_rst_rd",   rd_nclr, 32'd0);
    check("nclr_rst_rv",   {31'd0, rv_nclr}, 32'd0);
    rst = 1'b0;
    tick();
    check("nclr_busy_after", {31'd0, busy_nclr}, 32'd0);
    req(1'b0, 1'b1, 32'd9, '0);
    tick();
    check("nclr_rd9",    rd_nclr, 32'h0000ABCD);
    check("nclr_rd9_rv", {31'd0, rv_nclr}, 32'd1);
    req(1'b0, 1'b0, '0, '0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
